// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit core: operand width, register count and the
// status-flag layout used by the register file, ALU and decoder.
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic eq;
    logic lt;
  } flags_t;

endpackage

// File: rtl/reg_file_flag_reg.sv
// Status-flag register: captures the ALU compare outputs when enabled,
// cleared by the synchronous active-low reset.
module flag_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  flags_t d,
  output flags_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports feeding the ALU,
// one write port for the ALU/shifter result, plus the compare-flag register.
module reg_file #(
  parameter  int DATA_W   = cpu_pkg::DATA_W,
  parameter  int NUM_REGS = cpu_pkg::NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flag_we,
  input  logic              equal_in,
  input  logic              less_in,
  output logic              flag_eq,
  output logic              flag_lt
);

  import cpu_pkg::*;

  localparam logic [ADDR_W:0] DEPTH = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0] regs [NUM_REGS];
  flags_t            flags_d;
  flags_t            flags_q;

  // Reads see only stored state; forwarding wdata would close a loop through the ALU.
  assign rdata_a = ({1'b0, raddr_a} < DEPTH) ? regs[raddr_a] : '0;
  assign rdata_b = ({1'b0, raddr_b} < DEPTH) ? regs[raddr_b] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && ({1'b0, waddr} < DEPTH)) begin
      regs[waddr] <= wdata;
    end
  end

  assign flags_d.eq = equal_in;
  assign flags_d.lt = less_in;

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flag_we),
    .d     (flags_d),
    .q     (flags_q)
  );

  assign flag_eq = flags_q.eq;
  assign flag_lt = flags_q.lt;

endmodule
